// File: rtl/horloge_ctrl_pkg.sv
// Shared definitions for the horloge timekeeping controller.
//   mode_e        : user mode encoding driven on the 2-bit mode output
//   MAX_HOUR/MIN/SEC : terminal values of the time counters
//   wrap_inc6     : 6-bit increment with wrap to zero after a given maximum
package horloge_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    localparam logic [4:0] MAX_HOUR = 5'd23;
    localparam logic [5:0] MAX_MIN  = 6'd59;
    localparam logic [5:0] MAX_SEC  = 6'd59;

    function automatic logic [5:0] wrap_inc6(input logic [5:0] v, input logic [5:0] max);
        return (v == max) ? '0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] wrap_inc_hour(input logic [4:0] v);
        return (v == MAX_HOUR) ? '0 : v + 5'd1;
    endfunction

endpackage

// File: rtl/horloge_ctrl_tick_prescaler.sv
// tick_prescaler: divides the system clock down to a one-cycle tick pulse.
//   clock   in  system clock
//   reset_n in  asynchronous active-low reset
//   clear   in  restart the division period (counter and pending pulse)
//   tick    out registered pulse, high for one cycle every DIV cycles
module tick_prescaler #(
    parameter int unsigned DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;
    logic         r_tick;

    // Pulse is registered off the terminal count, so it appears in the
    // cycle after the counter reaches DIV-1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (clear) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + W'(1);
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/horloge_ctrl.sv
// horloge_ctrl: owns all time state of the horloge clock.
//   clock     in  system clock
//   reset_n   in  asynchronous active-low reset
//   btn_mode  in  debounced mode button level
//   btn_inc   in  debounced increment button level
//   hours     out 0..23
//   minutes   out 0..59
//   seconds   out 0..59
//   mode      out 0=RUN 1=SET_HOUR 2=SET_MIN
//   tick_1hz  out one-cycle pulse every TICK_DIV cycles
//   blink     out toggles on every tick_1hz
module horloge_ctrl
    import horloge_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       tick_1hz,
    output logic       blink
);

    mode_e      r_mode;
    logic [4:0] r_hour;
    logic [5:0] r_min;
    logic [5:0] r_sec;
    logic       r_blink;
    logic       r_mode_prev;
    logic       r_inc_prev;

    logic w_mode_press;
    logic w_inc_press;
    logic w_tick;
    logic w_clear;

    assign w_mode_press = btn_mode & ~r_mode_prev;
    assign w_inc_press  = btn_inc & ~r_inc_prev;
    // Leaving SET_MIN restarts the second so the next tick is a full period away.
    assign w_clear      = w_mode_press & (r_mode == MODE_SET_MIN);

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (w_clear),
        .tick    (w_tick)
    );

    // prev regs reset high so a button held through reset is not a press.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mode_prev <= 1'b1;
            r_inc_prev  <= 1'b1;
        end else begin
            r_mode_prev <= btn_mode;
            r_inc_prev  <= btn_inc;
        end
    end

    // Mode press has priority over both tick and inc press.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mode <= MODE_RUN;
            r_hour <= '0;
            r_min  <= '0;
            r_sec  <= '0;
        end else if (w_mode_press) begin
            unique case (r_mode)
                MODE_RUN:      r_mode <= MODE_SET_HOUR;
                MODE_SET_HOUR: r_mode <= MODE_SET_MIN;
                MODE_SET_MIN: begin
                    r_mode <= MODE_RUN;
                    r_sec  <= '0;
                end
                default:       r_mode <= MODE_RUN;
            endcase
        end else begin
            unique case (r_mode)
                MODE_RUN: begin
                    if (w_tick) begin
                        r_sec <= wrap_inc6(r_sec, MAX_SEC);
                        if (r_sec == MAX_SEC) begin
                            r_min <= wrap_inc6(r_min, MAX_MIN);
                            if (r_min == MAX_MIN) begin
                                r_hour <= wrap_inc_hour(r_hour);
                            end
                        end
                    end
                end
                MODE_SET_HOUR: begin
                    if (w_inc_press) begin
                        r_hour <= wrap_inc_hour(r_hour);
                    end
                end
                MODE_SET_MIN: begin
                    if (w_inc_press) begin
                        r_min <= wrap_inc6(r_min, MAX_MIN);
                    end
                end
                default: r_mode <= MODE_RUN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_blink <= 1'b0;
        end else if (w_tick) begin
            r_blink <= ~r_blink;
        end
    end

    assign hours    = r_hour;
    assign minutes  = r_min;
    assign seconds  = r_sec;
    assign mode     = r_mode;
    assign tick_1hz = w_tick;
    assign blink    = r_blink;

endmodule

// File: tb/tb_horloge_ctrl.sv
module tb_horloge_ctrl;

    localparam int DIV = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       tick_1hz;
    logic       blink;

    int errors = 0;
    int checks = 0;

    horloge_ctrl #(
        .TICK_DIV (DIV)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .hours    (hours),
        .minutes  (minutes),
        .seconds  (seconds),
        .mode     (mode),
        .tick_1hz (tick_1hz),
        .blink    (blink)
    );

    always #5 clock = ~clock;

    // Reference model: time kept as seconds-of-day, prescaler as cycles since epoch.
    int m_t;
    int m_phase;
    int m_tick;
    int m_mode;
    int m_blink;
    int m_prev_mode;
    int m_prev_inc;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_t = 0; m_phase = 0; m_tick = 0; m_mode = 0; m_blink = 0;
            m_prev_mode = 1; m_prev_inc = 1;
        end else begin
            int pm, pi, tk, cleared, h, mm;
            pm = (btn_mode && !m_prev_mode) ? 1 : 0;
            pi = (btn_inc && !m_prev_inc) ? 1 : 0;
            tk = m_tick;
            cleared = 0;
            if (pm) begin
                if (m_mode == 2) begin
                    m_mode = 0;
                    m_t = m_t - (m_t % 60);
                    cleared = 1;
                end else begin
                    m_mode = m_mode + 1;
                end
            end else if (m_mode == 0 && tk) begin
                m_t = (m_t + 1) % 86400;
            end else if (pi && m_mode == 1) begin
                h = ((m_t / 3600) + 1) % 24;
                m_t = h * 3600 + (m_t % 3600);
            end else if (pi && m_mode == 2) begin
                mm = (((m_t / 60) % 60) + 1) % 60;
                m_t = (m_t / 3600) * 3600 + mm * 60 + (m_t % 60);
            end
            if (tk) m_blink = 1 - m_blink;
            if (cleared) begin
                m_phase = 0;
                m_tick = 0;
            end else begin
                m_phase = m_phase + 1;
                m_tick = ((m_phase % DIV) == 0) ? 1 : 0;
            end
            m_prev_mode = btn_mode ? 1 : 0;
            m_prev_inc = btn_inc ? 1 : 0;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(posedge clock) begin
        #1;
        checks = checks + 1;
        if (int'(hours) != m_t / 3600 || int'(minutes) != (m_t / 60) % 60 ||
            int'(seconds) != m_t % 60 || int'(mode) != m_mode ||
            int'(tick_1hz) != m_tick || int'(blink) != m_blink) begin
            errors = errors + 1;
            $display("FAIL model_cmp t=%0t got %0d:%0d:%0d mode=%0d tick=%0d blink=%0d exp %0d:%0d:%0d mode=%0d tick=%0d blink=%0d",
                     $time, hours, minutes, seconds, mode, tick_1hz, blink,
                     m_t / 3600, (m_t / 60) % 60, m_t % 60, m_mode, m_tick, m_blink);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; step(1);
        btn_mode = 1'b0; step(1);
    endtask

    task automatic press_inc();
        btn_inc = 1'b1; step(1);
        btn_inc = 1'b0; step(1);
    endtask

    initial begin
        // Reset state
        step(3);
        check("rst_hours", int'(hours), 0);
        check("rst_seconds", int'(seconds), 0);
        check("rst_mode", int'(mode), 0);
        check("rst_tick", int'(tick_1hz), 0);
        check("rst_blink", int'(blink), 0);

        // Idle run: tick at cycles 4, 8, 12
        reset_n = 1'b1;
        step(4);
        check("c4_tick", int'(tick_1hz), 1);
        check("c4_sec", int'(seconds), 0);
        step(1);
        check("c5_sec", int'(seconds), 1);
        check("c5_blink", int'(blink), 1);
        check("c5_tick", int'(tick_1hz), 0);
        step(3);
        check("c8_tick", int'(tick_1hz), 1);
        step(5);
        check("c13_sec", int'(seconds), 3);
        check("c13_blink", int'(blink), 1);
        check("c13_mode", int'(mode), 0);

        // Set 23:59 then run up to midnight rollover
        press_mode();
        check("sethour_mode", int'(mode), 1);
        repeat (23) press_inc();
        check("set_h23", int'(hours), 23);
        press_mode();
        check("setmin_mode", int'(mode), 2);
        repeat (59) press_inc();
        check("set_m59", int'(minutes), 59);
        check("set_m59_h", int'(hours), 23);
        press_mode();
        check("run_sec_clr", int'(seconds), 0);
        check("run_mode", int'(mode), 0);
        step(4 * 58);
        check("s58_h", int'(hours), 23);
        check("s58_m", int'(minutes), 59);
        check("s58_s", int'(seconds), 58);
        step(4);
        check("s59_s", int'(seconds), 59);
        step(4);
        check("wrap_h", int'(hours), 0);
        check("wrap_m", int'(minutes), 0);
        check("wrap_s", int'(seconds), 0);

        // Hour setting wraps 23 -> 0
        press_mode();
        repeat (23) press_inc();
        check("hinc_23", int'(hours), 23);
        press_inc();
        check("hinc_wrap", int'(hours), 0);
        press_inc();
        check("hinc_25", int'(hours), 1);
        check("hinc_mode", int'(mode), 1);

        // Held inc is a single press; minute wrap does not carry
        press_mode();
        check("min_mode", int'(mode), 2);
        btn_inc = 1'b1; step(10);
        btn_inc = 1'b0; step(1);
        check("held_inc", int'(minutes), 1);
        repeat (58) press_inc();
        check("minc_59", int'(minutes), 59);
        press_inc();
        check("minc_wrap", int'(minutes), 0);
        check("minc_nocarry", int'(hours), 1);

        // Back to RUN, then mode and inc rising together
        press_mode();
        check("exit_mode", int'(mode), 0);
        check("exit_sec", int'(seconds), 0);
        btn_mode = 1'b1; btn_inc = 1'b1; step(1);
        check("both_mode", int'(mode), 1);
        check("both_hours", int'(hours), 1);
        btn_mode = 1'b0; btn_inc = 1'b0; step(1);
        press_mode();
        check("pre_rst_mode", int'(mode), 2);

        // Reset in SET_MIN with mode button held through release
        btn_mode = 1'b1;
        reset_n = 1'b0;
        #1;
        check("async_mode", int'(mode), 0);
        check("async_hours", int'(hours), 0);
        step(2);
        reset_n = 1'b1;
        step(2);
        check("held_rst_mode", int'(mode), 0);
        check("held_rst_min", int'(minutes), 0);
        btn_mode = 1'b0; step(2);
        check("c4b_tick", int'(tick_1hz), 1);
        // Mode press consumes the pending tick; time stays frozen
        btn_mode = 1'b1; step(1);
        check("tickmode_mode", int'(mode), 1);
        check("tickmode_sec", int'(seconds), 0);
        check("tickmode_blink", int'(blink), 1);
        btn_mode = 1'b0; step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
